// File: rtl/vector_pkg.sv
// Shared types and constants for the vector execution core.
package vector_pkg;

  localparam int LANES     = 16;
  localparam int LANE_W    = 32;
  localparam int VEC_W     = LANES * LANE_W;
  localparam int WIDE_W    = 2 * VEC_W;
  localparam int MEM_DEPTH = 512;
  localparam int ADDR_W    = 9;
  localparam int NUM_REGS  = 4;
  localparam int INSTR_W   = 13;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_STORE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_MUL   = 2'b11;

  typedef logic [VEC_W-1:0]  vec_t;
  typedef logic [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic [1:0]        opcode;
    logic [1:0]        rd;
    logic [ADDR_W-1:0] addr;
  } instr_t;

  // Preset pattern: lane j of word i holds i*16+j, negated on odd words.
  function automatic vec_t preset_word(input logic [ADDR_W-1:0] idx);
    vec_t              w;
    logic [LANE_W-1:0] v;
    w = '0;
    for (int j = 0; j < LANES; j++) begin
      v = LANE_W'(idx) * LANE_W'(LANES) + LANE_W'(j);
      if (idx[0]) v = -v;
      w[j*LANE_W +: LANE_W] = v;
    end
    return w;
  endfunction

endpackage

// File: rtl/vec_lane_alu.sv
// Lane-wise signed add / multiply; each lane yields a full 64-bit result.
module vec_lane_alu
  import vector_pkg::*;
(
  input  vec_t  a,
  input  vec_t  b,
  input  logic  op_mul,
  output wide_t result
);

  for (genvar j = 0; j < LANES; j++) begin : g_lane
    logic [2*LANE_W-1:0] a_ext;
    logic [2*LANE_W-1:0] b_ext;

    // Sign-extend both lanes so the add keeps its carry and the low 64 bits
    // of the product match a signed 32x32 multiply.
    assign a_ext = {{LANE_W{a[j*LANE_W+LANE_W-1]}}, a[j*LANE_W +: LANE_W]};
    assign b_ext = {{LANE_W{b[j*LANE_W+LANE_W-1]}}, b[j*LANE_W +: LANE_W]};

    assign result[j*2*LANE_W +: 2*LANE_W] = op_mul ? (a_ext * b_ext) : (a_ext + b_ext);
  end

endmodule

// File: rtl/vector_exec_core.sv
// Single-issue vector core: 4 x 512-bit register file, 512 x 512-bit memory,
// one LOAD/STORE/ADD/MUL instruction per valid clock.
module vector_exec_core
  import vector_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set,
  input  logic                      valid,
  input  logic [INSTR_W-1:0]        instruction,
  output logic signed [VEC_W-1:0]   A1,
  output logic signed [VEC_W-1:0]   A2,
  output logic signed [VEC_W-1:0]   A3,
  output logic signed [VEC_W-1:0]   A4
);

  vec_t   regs [NUM_REGS];
  vec_t   mem  [MEM_DEPTH];
  instr_t instr;
  logic   exec;
  logic   op_mul;
  wide_t  alu_res;
  vec_t   alu_lo;
  vec_t   alu_hi;

  assign instr  = instruction;
  // Memory preset takes the cycle; no instruction executes alongside it.
  assign exec   = valid && !set;
  assign op_mul = (instr.opcode == OP_MUL);

  vec_lane_alu u_alu (
    .a      (regs[0]),
    .b      (regs[1]),
    .op_mul (op_mul),
    .result (alu_res)
  );

  // Split each 64-bit lane result into low halves (R2) and high halves (R3).
  always_comb begin
    alu_lo = '0;
    alu_hi = '0;
    for (int j = 0; j < LANES; j++) begin
      alu_lo[j*LANE_W +: LANE_W] = alu_res[j*2*LANE_W +: LANE_W];
      alu_hi[j*LANE_W +: LANE_W] = alu_res[j*2*LANE_W + LANE_W +: LANE_W];
    end
  end

  // Register file: async clear, LOAD writes R[rd], ADD/MUL write R2/R3.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (exec) begin
      case (instr.opcode)
        OP_LOAD: regs[instr.rd] <= mem[instr.addr];
        OP_ADD,
        OP_MUL: begin
          regs[2] <= alu_lo;
          regs[3] <= alu_hi;
        end
        default: ;
      endcase
    end
  end

  // Data memory: contents survive reset, but no write happens while reset is low.
  always_ff @(posedge clk or negedge reset) begin
    if (reset) begin
      if (set) begin
        for (int i = 0; i < MEM_DEPTH; i++) mem[i] <= preset_word(ADDR_W'(i));
      end else if (valid && instr.opcode == OP_STORE) begin
        mem[instr.addr] <= regs[instr.rd];
      end
    end
  end

  assign A1 = regs[0];
  assign A2 = regs[1];
  assign A3 = regs[2];
  assign A4 = regs[3];

endmodule

// File: tb/tb_vector_exec_core.sv
module tb_vector_exec_core;
  import vector_pkg::*;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    set = 1'b0;
  logic                    valid = 1'b0;
  logic [12:0]             instruction = '0;
  logic signed [VEC_W-1:0] A1, A2, A3, A4;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    vec_t r3;
    vec_t r2;
    vec_t r1;
    vec_t r0;
  } snap_t;

  snap_t exp_q[$];
  vec_t  m_reg [4];
  vec_t  m_mem [512];

  vector_exec_core dut (
    .clk         (clk),
    .reset       (reset),
    .set         (set),
    .valid       (valid),
    .instruction (instruction),
    .A1          (A1),
    .A2          (A2),
    .A3          (A3),
    .A4          (A4)
  );

  always #5 clk = ~clk;

  function automatic vec_t preset_ref(input int i);
    vec_t w;
    int   v;
    w = '0;
    for (int j = 0; j < 16; j++) begin
      v = i * 16 + j;
      if (i % 2 == 1) v = -v;
      w[j*32 +: 32] = v;
    end
    return w;
  endfunction

  // Reference model of one clock edge of the ISA.
  task automatic model_step(input logic [1:0] op, input logic [1:0] rd,
                            input logic [8:0] addr, input logic v, input logic s);
    vec_t   n2, n3;
    int     a, b;
    longint r;
    if (!reset) begin
      for (int k = 0; k < 4; k++) m_reg[k] = '0;
    end else if (s) begin
      for (int i = 0; i < 512; i++) m_mem[i] = preset_ref(i);
    end else if (v) begin
      case (op)
        2'b00: m_reg[rd] = m_mem[addr];
        2'b01: m_mem[addr] = m_reg[rd];
        default: begin
          n2 = '0;
          n3 = '0;
          for (int j = 0; j < 16; j++) begin
            a = m_reg[0][j*32 +: 32];
            b = m_reg[1][j*32 +: 32];
            r = (op == 2'b11) ? longint'(a) * longint'(b) : longint'(a) + longint'(b);
            n2[j*32 +: 32] = r[31:0];
            n3[j*32 +: 32] = r[63:32];
          end
          m_reg[2] = n2;
          m_reg[3] = n3;
        end
      endcase
    end
  endtask

  // Drive one cycle of stimulus and push the expected register state.
  task automatic drive(input logic [1:0] op, input logic [1:0] rd,
                       input logic [8:0] addr, input logic v, input logic s);
    @(negedge clk);
    valid       = v;
    set         = s;
    instruction = {op, rd, addr};
    model_step(op, rd, addr, v, s);
    exp_q.push_back('{r3: m_reg[3], r2: m_reg[2], r1: m_reg[1], r0: m_reg[0]});
    @(posedge clk);
    #2;
    valid = 1'b0;
    set   = 1'b0;
  endtask

  // Scoreboard monitor: compare all four registers just after each edge.
  initial begin
    snap_t e;
    vec_t  got [4];
    vec_t  exp_r [4];
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        got[0] = A1; got[1] = A2; got[2] = A3; got[3] = A4;
        exp_r[0] = e.r0; exp_r[1] = e.r1; exp_r[2] = e.r2; exp_r[3] = e.r3;
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (got[k] !== exp_r[k]) begin
            errors++;
            $display("FAIL sb_reg%0d got=%h exp=%h", k, got[k], exp_r[k]);
          end
        end
      end
    end
  end

  task automatic test_reset;
    #1 reset = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) m_reg[k] = '0;
    checks++; if (A1 !== '0) begin errors++; $display("FAIL reset_A1 got=%h exp=0", A1); end
    checks++; if (A2 !== '0) begin errors++; $display("FAIL reset_A2 got=%h exp=0", A2); end
    checks++; if (A3 !== '0) begin errors++; $display("FAIL reset_A3 got=%h exp=0", A3); end
    checks++; if (A4 !== '0) begin errors++; $display("FAIL reset_A4 got=%h exp=0", A4); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_set_and_load;
    logic [31:0] lane, expv;
    drive(2'b00, 2'd0, 9'd0, 1'b0, 1'b1);
    drive(OP_LOAD, 2'd0, 9'd4, 1'b1, 1'b0);
    drive(OP_LOAD, 2'd1, 9'd3, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      lane = A1[j*32 +: 32];
      expv = 32'(64 + j);
      checks++;
      if (lane !== expv) begin errors++; $display("FAIL load_A1_lane%0d got=%h exp=%h", j, lane, expv); end
      lane = A2[j*32 +: 32];
      expv = 32'(-(48 + j));
      checks++;
      if (lane !== expv) begin errors++; $display("FAIL load_A2_lane%0d got=%h exp=%h", j, lane, expv); end
    end
    lane = A2[31:0];
    checks++;
    if (lane !== 32'hFFFF_FFD0) begin errors++; $display("FAIL load_A2_lane0_hex got=%h exp=ffffffd0", lane); end
  endtask

  task automatic test_add;
    logic [31:0] lane;
    drive(OP_LOAD, 2'd0, 9'd2, 1'b1, 1'b0);
    drive(OP_LOAD, 2'd1, 9'd3, 1'b1, 1'b0);
    drive(OP_ADD, 2'd3, 9'd77, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      lane = A3[j*32 +: 32];
      checks++;
      if (lane !== 32'hFFFF_FFF0) begin errors++; $display("FAIL add_A3_lane%0d got=%h exp=fffffff0", j, lane); end
      lane = A4[j*32 +: 32];
      checks++;
      if (lane !== 32'hFFFF_FFFF) begin errors++; $display("FAIL add_A4_lane%0d got=%h exp=ffffffff", j, lane); end
    end
  endtask

  task automatic test_store_roundtrip;
    logic [31:0] lane;
    drive(OP_STORE, 2'd2, 9'd100, 1'b1, 1'b0);
    drive(OP_ADD, 2'd1, 9'd5, 1'b0, 1'b0);
    drive(OP_LOAD, 2'd0, 9'd7, 1'b0, 1'b0);
    drive(OP_LOAD, 2'd0, 9'd100, 1'b1, 1'b0);
    for (int j = 0; j < 16; j++) begin
      lane = A1[j*32 +: 32];
      checks++;
      if (lane !== 32'hFFFF_FFF0) begin errors++; $display("FAIL store_rt_lane%0d got=%h exp=fffffff0", j, lane); end
    end
  endtask

  task automatic test_mul;
    logic [31:0] lane;
    drive(OP_LOAD, 2'd0, 9'd4, 1'b1, 1'b0);
    drive(OP_LOAD, 2'd1, 9'd3, 1'b1, 1'b0);
    drive(OP_MUL, 2'd0, 9'd0, 1'b1, 1'b0);
    lane = A3[31:0];
    checks++; if (lane !== 32'hFFFF_F400) begin errors++; $display("FAIL mul_A3_lane0 got=%h exp=fffff400", lane); end
    lane = A4[31:0];
    checks++; if (lane !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_A4_lane0 got=%h exp=ffffffff", lane); end
    lane = A3[511:480];
    checks++; if (lane !== 32'hFFFF_EC8F) begin errors++; $display("FAIL mul_A3_lane15 got=%h exp=ffffec8f", lane); end
    lane = A4[511:480];
    checks++; if (lane !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mul_A4_lane15 got=%h exp=ffffffff", lane); end
  endtask

  task automatic test_set_priority;
    logic [31:0] lane;
    drive(OP_ADD, 2'd0, 9'd0, 1'b1, 1'b1);
    lane = A3[31:0];
    checks++; if (lane !== 32'hFFFF_F400) begin errors++; $display("FAIL setprio_A3_held got=%h exp=fffff400", lane); end
    lane = A4[511:480];
    checks++; if (lane !== 32'hFFFF_FFFF) begin errors++; $display("FAIL setprio_A4_held got=%h exp=ffffffff", lane); end
    drive(OP_LOAD, 2'd0, 9'd100, 1'b1, 1'b0);
    lane = A1[31:0];
    checks++; if (lane !== 32'd1600) begin errors++; $display("FAIL setprio_mem_preset got=%h exp=%h", lane, 32'd1600); end
  endtask

  task automatic test_async_reset;
    logic [31:0] lane;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (A1 !== '0) begin errors++; $display("FAIL async_rst_A1 got=%h exp=0", A1); end
    checks++; if (A2 !== '0) begin errors++; $display("FAIL async_rst_A2 got=%h exp=0", A2); end
    checks++; if (A3 !== '0) begin errors++; $display("FAIL async_rst_A3 got=%h exp=0", A3); end
    checks++; if (A4 !== '0) begin errors++; $display("FAIL async_rst_A4 got=%h exp=0", A4); end
    drive(OP_LOAD, 2'd0, 9'd4, 1'b1, 1'b0);
    drive(OP_STORE, 2'd0, 9'd4, 1'b1, 1'b1);
    reset = 1'b1;
    drive(OP_LOAD, 2'd0, 9'd4, 1'b1, 1'b0);
    lane = A1[31:0];
    checks++; if (lane !== 32'd64) begin errors++; $display("FAIL post_rst_load got=%h exp=%h", lane, 32'd64); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] op, rd;
    logic [8:0] addr;
    logic       v;
    for (int n = 0; n < 60; n++) begin
      op   = 2'($urandom_range(0, 3));
      rd   = 2'($urandom_range(0, 3));
      addr = (n % 3 == 0) ? 9'd100 : 9'($urandom_range(0, 511));
      v    = ($urandom_range(0, 9) < 8);
      drive(op, rd, addr, v, 1'b0);
    end
  endtask

  initial begin
    test_reset;
    test_set_and_load;
    test_add;
    test_store_roundtrip;
    test_mul;
    test_set_priority;
    test_async_reset;
    test_back_to_back;
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vector_exec_core.md
Name: vector_exec_core

Overview:
- Single-issue vector execution core.
- Combines a 4-entry x 512-bit vector register file, a 512-word x 512-bit data memory, and a 16-lane signed arithmetic unit.
- Executes one 13-bit instruction per valid clock: load, store, lane-wise add, or lane-wise multiply.
- Exposes all four vector registers as outputs for observation by the surrounding processor/testbench.

Parameters:
- LANES, 16, number of 32-bit lanes per vector.
- LANE_W, 32, lane width in bits; vector width = LANES*LANE_W = 512.
- MEM_DEPTH, 512, number of memory words; address width 9.

Ports:
- clk  in  1  single clock; rising-edge active.
- reset  in  1  asynchronous active-low reset.
- set  in  1  synchronous memory preset.
- valid  in  1  instruction valid; sampled on the rising edge.
- instruction  in  13  [12:11] opcode, [10:9] register index rd, [8:0] memory address.
- A1  out  512 signed  register R0.
- A2  out  512 signed  register R1.
- A3  out  512 signed  register R2.
- A4  out  512 signed  register R3.

Behaviour:
- Reset: reset=0 immediately clears R0..R3, so A1..A4 = 0. Reset does not clear memory. Reset has priority over set and valid.
- Set: with reset=1 and set=1 at a rising edge, every memory word i is written.
  - Lane j of word i = i*16+j when i is even.
  - Lane j of word i = -(i*16+j) (two's complement) when i is odd.
  - Instruction execution is suppressed that cycle; registers hold.
- Execution: with reset=1, set=0, valid=1, the instruction executes in the same rising edge. Latency is 1 clock: results appear on A1..A4 or in memory after that edge. With valid=0 nothing changes.
- Reads of registers and memory are combinational from current state.
- Opcode 00 LOAD: R[rd] <= mem[addr].
- Opcode 01 STORE: mem[addr] <= R[rd]; registers unchanged.
- Opcode 10 ADD, lane-wise for j=0..15:
  - s = sext64(R0[j]) + sext64(R1[j]).
  - R2 lane j <= s[31:0]; R3 lane j <= s[63:32].
  - rd and addr are ignored.
- Opcode 11 MUL: same as ADD, with p = signed 32x32 -> 64-bit product. R2 receives the low halves, R3 the high halves.
- Lane j occupies bits [32j+31:32j].
- ADD never loses precision: the 33-bit sum is sign-extended into R3.
- If rd is R0/R1 for a LOAD, the new value is used by the next ADD/MUL only.
- LOAD followed by STORE to the same address: the store writes the register value present at that edge.
- Reset asserted mid-sequence aborts at once. After release, the next valid rising edge executes normally.

Decomposition:
- Shared package vector_pkg holds:
  - LANES, LANE_W, VEC_W=512, ADDR_W=9.
  - Opcode constants OP_LOAD=2'b00, OP_STORE=2'b01, OP_ADD=2'b10, OP_MUL=2'b11.
  - Typedef for a 512-bit vector and a 1024-bit widened result.
- One sub-module: vec_lane_alu, purely combinational.
  - Inputs: two 512-bit vectors and an op bit (0=add, 1=mul).
  - Output: 1024-bit result with lane j at bits [64j+63:64j].
  - Instantiated once.
- Register file and memory stay inline in vector_exec_core.

Test Plan:
- Reset:
  - Load garbage into R0..R3, pulse reset=0 between edges.
  - A1..A4 go to 0 immediately, without waiting for a clock.
  - Memory content survives: a later LOAD of word 4 returns lane0=64.
- Set and load:
  - set=1 for one edge, then LOAD rd=0 addr=4, then LOAD rd=1 addr=3.
  - A1 lane j = 64+j.
  - A2 lane j = -(48+j); lane0 = 0xFFFFFFD0.
- ADD sign extension:
  - R0 = word 2 (32+j), R1 = word 3 (-(48+j)), ADD.
  - A3 lane j = -16 (0xFFFFFFF0).
  - A4 lane j = 0xFFFFFFFF.
- MUL:
  - R0 = word 4, R1 = word 3, MUL.
  - A3 lane0 = 0xFFFFF400 (-3072), A4 lane0 = 0xFFFFFFFF.
  - A3 lane15 = 79*(-63) = -4977 (0xFFFFEC8F), A4 lane15 = 0xFFFFFFFF.
- STORE round trip:
  - After the ADD test, STORE rd=2 addr=100, then LOAD rd=0 addr=100.
  - A1 lane j = 0xFFFFFFF0.
  - valid=0 cycles in between leave all registers unchanged.
- Set priority:
  - set=1 together with valid=1 and an ADD instruction.
  - A3/A4 unchanged; memory preset.
